// File: rtl/user_io_link_status_csr.sv
// user_io_link_status_csr: synchronised link status, sticky alarms, link-down counters, CSR port and UIO status beat stream
//  clk_per/reset_per         clock, asynchronous active-high reset
//  i_stat_*/i_*_alarm        per-link status and alarms, asynchronous to clk_per
//  i_csr_*/o_csr_*           CSR access; reads are registered (1-cycle ack)
//  o_uio_rs_*/i_uio_rs_afull status beat stream and consumer back-pressure
module user_io_link_status_csr #(
  parameter int NUM_LINKS = 8,
  parameter int UIO_PORTS_WIDTH = 128,
  parameter int CNT_WIDTH = 16,
  parameter int STAT_PERIOD = 256
) (
  input  logic                       clk_per,
  input  logic                       reset_per,
  input  logic [NUM_LINKS-1:0]       i_stat_chan_up,
  input  logic [NUM_LINKS-1:0]       i_stat_lane_up,
  input  logic [NUM_LINKS-1:0]       i_fatal_alarm,
  input  logic [NUM_LINKS-1:0]       i_corr_alarm,
  input  logic [15:0]                i_csr_addr,
  input  logic [63:0]                i_csr_data,
  input  logic                       i_csr_wr_vld,
  input  logic                       i_csr_rd_vld,
  output logic [63:0]                o_csr_data,
  output logic                       o_csr_rd_ack,
  output logic                       o_uio_rs_vld,
  output logic [UIO_PORTS_WIDTH-1:0] o_uio_rs_data,
  input  logic                       i_uio_rs_afull
);
  localparam int TW = $clog2(STAT_PERIOD);
  typedef enum logic [1:0] {IDLE, PEND, SEND} state_t;
  state_t st_q, st_d;
  logic [3:0][NUM_LINKS-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [NUM_LINKS-1:0] chan_p_q, chan_p_d, fall;
  logic [NUM_LINKS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [15:0] stk_q, stk_d, seq_q, seq_d;
  logic [63:0] scratch_q, scratch_d, rd_data_q, rd_data_d, cv;
  logic [31:0] snap_q, snap_d, s;
  logic [TW-1:0] timer_q, timer_d;
  logic en_q, en_d, rd_ack_q, rd_ack_d, req, cnt_hit;
  logic [12:0] cidx;
  // vectors are stacked {fatal, corr, chan, lane} and zero-extended to 8 bits each
  assign s = {8'(s2_q[3]), 8'(s2_q[2]), 8'(s2_q[1]), 8'(s2_q[0])};
  assign fall = chan_p_q & ~s2_q[1];
  assign cidx = i_csr_addr[15:3] - 13'd4;
  assign cnt_hit = i_csr_addr[2:0] == 3'd0 && i_csr_addr[15:3] >= 13'd4 &&
                   i_csr_addr[15:3] < 13'(4 + NUM_LINKS);
  assign req = timer_q == '0 || s != snap_q;
  always_comb begin
    s1_d = {i_fatal_alarm, i_corr_alarm, i_stat_chan_up, i_stat_lane_up};
    s2_d = s1_q;
    chan_p_d = s2_q[1];
    // an alarm still high in the clear cycle keeps its sticky bit set
    stk_d = (stk_q & ~((i_csr_wr_vld && i_csr_addr == 16'h10) ? i_csr_data[15:0] : 16'h0)) |
            {s[31:24], s[23:16]};
    scratch_d = (i_csr_wr_vld && i_csr_addr == 16'h08) ? i_csr_data : scratch_q;
    en_d = (i_csr_wr_vld && i_csr_addr == 16'h18) ? i_csr_data[0] : en_q;
    cnt_d = cnt_q;
    cv = '0;
    for (int i = 0; i < NUM_LINKS; i++) begin
      // a clear coinciding with a drop counts that drop
      cnt_d[i] = (i_csr_wr_vld && cnt_hit && cidx == 13'(i)) ? CNT_WIDTH'(fall[i]) :
                 (fall[i] && !(&cnt_q[i])) ? cnt_q[i] + CNT_WIDTH'(1) : cnt_q[i];
      cv = (cidx == 13'(i)) ? 64'(cnt_q[i]) : cv;
    end
    rd_ack_d = i_csr_rd_vld;
    rd_data_d = !i_csr_rd_vld ? 64'h0 :
                i_csr_addr == 16'h00 ? {32'h0, s} :
                i_csr_addr == 16'h08 ? scratch_q :
                i_csr_addr == 16'h10 ? {48'h0, stk_q} :
                i_csr_addr == 16'h18 ? {63'h0, en_q} :
                cnt_hit ? cv : 64'hDEADBEEFDEADBEEF;
    timer_d = timer_q == '0 ? TW'(STAT_PERIOD - 1) : timer_q - TW'(1);
    // requests are level conditions, so anything arriving in PEND/SEND folds into one beat
    st_d = (st_q == SEND || (st_q == PEND && !en_q) || (st_q == IDLE && !(req && en_q))) ? IDLE :
           i_uio_rs_afull ? PEND : SEND;
    snap_d = st_q == SEND ? s : snap_q;
    seq_d = st_q == SEND ? seq_q + 16'd1 : seq_q;
  end
  always_ff @(posedge clk_per or posedge reset_per) begin
    if (reset_per) begin
      s1_q <= '0;
      s2_q <= '0;
      chan_p_q <= '0;
      cnt_q <= '0;
      stk_q <= '0;
      scratch_q <= '0;
      en_q <= 1'b1;
      rd_ack_q <= 1'b0;
      rd_data_q <= '0;
      timer_q <= TW'(STAT_PERIOD - 1);
      st_q <= IDLE;
      snap_q <= '0;
      seq_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      chan_p_q <= chan_p_d;
      cnt_q <= cnt_d;
      stk_q <= stk_d;
      scratch_q <= scratch_d;
      en_q <= en_d;
      rd_ack_q <= rd_ack_d;
      rd_data_q <= rd_data_d;
      timer_q <= timer_d;
      st_q <= st_d;
      snap_q <= snap_d;
      seq_q <= seq_d;
    end
  end
  assign o_csr_data = rd_data_q;
  assign o_csr_rd_ack = rd_ack_q;
  assign o_uio_rs_vld = st_q == SEND;
  assign o_uio_rs_data = o_uio_rs_vld ? UIO_PORTS_WIDTH'({seq_q, stk_q, s}) : '0;
endmodule

// File: tb/tb_user_io_link_status_csr.sv
// tb_user_io_link_status_csr: directed checks of the link status CSR block
module tb_user_io_link_status_csr;
  logic clk_per = 1'b0, reset_per = 1'b1;
  logic [7:0] chan = '0, lane = '0, fat = '0, corr = '0;
  logic [15:0] addr = '0;
  logic [63:0] wdata = '0;
  logic wr = 1'b0, rd = 1'b0, afull = 1'b0;
  logic [63:0] csr_data, csr_data4;
  logic ack, ack4, vld, vld4;
  logic [127:0] udata, udata4;
  int ncmp = 0, nmis = 0, cyc = 0, beats = 0, n, b0;
  always #5 clk_per = ~clk_per;
  user_io_link_status_csr #(.NUM_LINKS(8), .UIO_PORTS_WIDTH(128), .CNT_WIDTH(2), .STAT_PERIOD(16)) dut (
    .clk_per(clk_per), .reset_per(reset_per),
    .i_stat_chan_up(chan), .i_stat_lane_up(lane), .i_fatal_alarm(fat), .i_corr_alarm(corr),
    .i_csr_addr(addr), .i_csr_data(wdata), .i_csr_wr_vld(wr), .i_csr_rd_vld(rd),
    .o_csr_data(csr_data), .o_csr_rd_ack(ack),
    .o_uio_rs_vld(vld), .o_uio_rs_data(udata), .i_uio_rs_afull(afull));
  user_io_link_status_csr #(.NUM_LINKS(4), .UIO_PORTS_WIDTH(128), .CNT_WIDTH(2), .STAT_PERIOD(16)) dut4 (
    .clk_per(clk_per), .reset_per(reset_per),
    .i_stat_chan_up(chan[3:0]), .i_stat_lane_up(lane[3:0]), .i_fatal_alarm(fat[3:0]),
    .i_corr_alarm(corr[3:0]),
    .i_csr_addr(addr), .i_csr_data(wdata), .i_csr_wr_vld(wr), .i_csr_rd_vld(rd),
    .o_csr_data(csr_data4), .o_csr_rd_ack(ack4),
    .o_uio_rs_vld(vld4), .o_uio_rs_data(udata4), .i_uio_rs_afull(afull));
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk_per);
      #1;
      cyc++;
      if (vld) beats++;
    end
  endtask
  task automatic to_beat(output int k);
    k = 0;
    do begin
      step(1);
      k++;
    end while (!vld && k < 64);
  endtask
  task automatic csr_wr(input logic [15:0] a, input logic [63:0] d);
    addr = a;
    wdata = d;
    wr = 1'b1;
    step(1);
    wr = 1'b0;
  endtask
  task automatic csr_rd(input logic [15:0] a, input logic [63:0] exp, input string tag);
    addr = a;
    rd = 1'b1;
    step(1);
    rd = 1'b0;
    check({tag, " ack"}, 128'(ack), 128'h1);
    check(tag, 128'(csr_data), 128'(exp));
  endtask
  initial begin
    step(2);
    check("rst vld", 128'(vld), 128'h0);
    check("rst ack", 128'(ack), 128'h0);
    check("rst csr_data", 128'(csr_data), 128'h0);
    check("rst udata", udata, 128'h0);
    check("rst vld4", 128'(vld4), 128'h0);
    check("rst udata4", udata4, 128'h0);
    reset_per = 1'b0;
    cyc = 0;
    // periodic beats, all inputs idle
    to_beat(n);
    check("t1 first beat cycle", 128'(n), 128'd16);
    check("t1 beat0 data", udata, 128'h0);
    to_beat(n);
    check("t1 period1", 128'(n), 128'd16);
    check("t1 beat1 data", udata, 128'h0001_0000_0000_0000);
    to_beat(n);
    check("t1 period2", 128'(n), 128'd16);
    check("t1 beat2 data", udata, 128'h0002_0000_0000_0000);
    // status change beats and a link drop
    chan = 8'h0F;
    to_beat(n);
    check("t2 chan up latency", 128'(n), 128'd3);
    check("t2 chan up data", udata, 128'h0003_0000_0000_0F00);
    chan = 8'h0B;
    to_beat(n);
    check("t2 drop latency", 128'(n), 128'd3);
    check("t2 drop data", udata, 128'h0004_0000_0000_0B00);
    csr_rd(16'h30, 64'h1, "t2 cnt2");
    csr_rd(16'h20, 64'h0, "t2 cnt0");
    csr_wr(16'h30, 64'h0);
    csr_rd(16'h30, 64'h0, "t2 cnt2 cleared");
    // sticky alarms with beats disabled
    csr_wr(16'h18, 64'h0);
    b0 = beats;
    csr_rd(16'h18, 64'h0, "t3 ctrl off");
    fat = 8'h20;
    step(3);
    fat = 8'h00;
    step(3);
    csr_rd(16'h10, 64'h2000, "t3 sticky set");
    csr_wr(16'h10, 64'h2000);
    csr_rd(16'h10, 64'h0, "t3 sticky w1c");
    fat = 8'h20;
    step(3);
    csr_wr(16'h10, 64'h2000);
    csr_rd(16'h10, 64'h2000, "t3 w1c vs alarm");
    fat = 8'h00;
    step(3);
    csr_wr(16'h10, 64'h2000);
    csr_rd(16'h10, 64'h0, "t3 sticky clean");
    lane = 8'h01;
    step(3);
    check("t3 no beats when disabled", 128'(beats - b0), 128'h0);
    csr_wr(16'h18, 64'h1);
    to_beat(n);
    check("t3 enable latency", 128'(n), 128'd1);
    check("t3 enable data", udata, 128'h0005_0000_0000_0B01);
    // back-pressure holds one merged beat
    afull = 1'b1;
    b0 = beats;
    step(10);
    lane = 8'h03;
    step(20);
    corr = 8'h04;
    step(20);
    check("t4 no beats under afull", 128'(beats - b0), 128'h0);
    while (cyc % 16 != 2) step(1);
    afull = 1'b0;
    b0 = beats;
    step(1);
    check("t4 release vld", 128'(vld), 128'h1);
    check("t4 release data", udata, 128'h0006_0004_0004_0B03);
    step(7);
    check("t4 single beat", 128'(beats - b0), 128'h1);
    // counter saturation and clear against a drop
    for (int i = 0; i < 5; i++) begin
      chan = 8'h0A;
      step(3);
      chan = 8'h0B;
      step(3);
    end
    csr_rd(16'h20, 64'h3, "t5 cnt0 saturated");
    chan = 8'h0A;
    step(2);
    csr_wr(16'h20, 64'h0);
    csr_rd(16'h20, 64'h1, "t5 clear with drop");
    chan = 8'h0B;
    step(3);
    // CSR map
    csr_wr(16'h08, 64'hA5A5A5A5A5A5A5A5);
    addr = 16'h08;
    wdata = 64'h5A5A5A5A5A5A5A5A;
    wr = 1'b1;
    rd = 1'b1;
    check("t6 ack not early", 128'(ack), 128'h0);
    step(1);
    wr = 1'b0;
    rd = 1'b0;
    check("t6 rw ack", 128'(ack), 128'h1);
    check("t6 rw old data", 128'(csr_data), 128'hA5A5A5A5A5A5A5A5);
    csr_rd(16'h08, 64'h5A5A5A5A5A5A5A5A, "t6 scratch");
    csr_rd(16'h00, 64'h0000_0000_0004_0B03, "t6 status");
    csr_wr(16'h18, 64'hFF);
    csr_rd(16'h18, 64'h1, "t6 ctrl mask");
    csr_rd(16'h60, 64'hDEADBEEFDEADBEEF, "t6 cnt beyond links");
    csr_rd(16'h0C, 64'hDEADBEEFDEADBEEF, "t6 unaligned");
    addr = 16'h40;
    rd = 1'b1;
    step(1);
    rd = 1'b0;
    check("t6 dut4 ack", 128'(ack4), 128'h1);
    check("t6 dut4 0x40", 128'(csr_data4), 128'hDEADBEEFDEADBEEF);
    check("t6 dut 0x40 cnt4", 128'(csr_data), 128'h0);
    // reset mid-operation
    fat = '0;
    corr = '0;
    chan = '0;
    lane = '0;
    reset_per = 1'b1;
    #1;
    check("rst2 vld", 128'(vld), 128'h0);
    check("rst2 csr_data", 128'(csr_data), 128'h0);
    step(2);
    reset_per = 1'b0;
    cyc = 0;
    csr_rd(16'h08, 64'h0, "rst2 scratch");
    csr_rd(16'h18, 64'h1, "rst2 ctrl");
    csr_rd(16'h10, 64'h0, "rst2 sticky");
    to_beat(n);
    check("rst2 first beat cycle", 128'(n), 128'd13);
    check("rst2 beat data", udata, 128'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end
endmodule
